// File: rtl/video_pixel_sequencer.sv
// 640x480@60 raster sequencer: free-running timing counters, a small pixel
// FIFO fed by a valid/ready source, and registered RGB/sync/active outputs
// for the TMDS encoders. Underflow or frame misalignment blanks the pixel,
// flushes the FIFO and waits for the next start-of-frame pixel.
module video_pixel_sequencer #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clock_25,
    input  logic        reset_n,
    input  logic [23:0] pix_data,
    input  logic        pix_sof,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        syncH,
    output logic        syncV,
    output logic        actvA,
    output logic        frame_start,
    output logic        desync,
    output logic [7:0]  underflow_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [XW-1:0] X_LAST     = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT      = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_SYNC_ON  = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] X_SYNC_OFF = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] Y_LAST     = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_ACT      = YW'(V_ACTIVE);
    localparam logic [YW-1:0] Y_SYNC_ON  = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] Y_SYNC_OFF = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [AW:0]   CNT_FULL   = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] WAIT_SOF = 2'd0;
    localparam logic [1:0] ARMED    = 2'd1;
    localparam logic [1:0] STREAM   = 2'd2;

    logic [XW-1:0] contX;
    logic [YW-1:0] contY;
    logic [1:0]    state;

    logic [24:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [24:0]   head;

    logic x_last, y_last, at_origin, in_active;
    logic full, empty, accept, push, pop, pop_req, underflow, misalign, err;

    assign x_last    = (contX == X_LAST);
    assign y_last    = (contY == Y_LAST);
    assign at_origin = (contX == '0) && (contY == '0);
    assign in_active = (contX < X_ACT) && (contY < Y_ACT);

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign head  = fifo_mem[rd_ptr];

    // FIFO is always empty in WAIT_SOF, so ready can be unconditional there
    assign pix_ready = reset_n && ((state == WAIT_SOF) || !full);
    assign accept    = pix_valid && pix_ready;

    // no bypass path: an empty FIFO at a required pop is an underflow even
    // if a pixel is being pushed in the same cycle
    assign pop_req   = (state == STREAM) && in_active;
    assign underflow = pop_req && empty;
    assign misalign  = pop_req && !empty && (head[24] != at_origin);
    assign err       = underflow || misalign;
    assign pop       = pop_req && !empty && !misalign;
    // flush wins over a same-cycle push; WAIT_SOF keeps only the sof pixel
    assign push      = accept && !err && ((state != WAIT_SOF) || pix_sof);

    // free-running raster counters, unaffected by stream state
    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            contX <= '0;
            contY <= '0;
        end else if (x_last) begin
            contX <= '0;
            contY <= y_last ? '0 : contY + YW'(1);
        end else begin
            contX <= contX + XW'(1);
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clock_25) begin
        if (push) fifo_mem[wr_ptr] <= {pix_sof, pix_data};
    end

    // FIFO pointers and occupancy, flushed on any stream error
    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (err) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
        end
    end

    // stream state: hunt for sof, pre-fill until frame wrap, then stream
    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_SOF;
        end else begin
            case (state)
                WAIT_SOF: if (accept && pix_sof) state <= ARMED;
                ARMED:    if (x_last && y_last)  state <= STREAM;
                STREAM:   if (err)               state <= WAIT_SOF;
                default:                         state <= WAIT_SOF;
            endcase
        end
    end

    // registered outputs, all one cycle behind the counters
    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            red           <= '0;
            green         <= '0;
            blue          <= '0;
            syncH         <= 1'b0;
            syncV         <= 1'b0;
            actvA         <= 1'b0;
            frame_start   <= 1'b0;
            desync        <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            syncH       <= (contX >= X_SYNC_ON) && (contX < X_SYNC_OFF);
            syncV       <= (contY >= Y_SYNC_ON) && (contY < Y_SYNC_OFF);
            actvA       <= in_active;
            frame_start <= at_origin;
            red         <= pop ? head[23:16] : 8'd0;
            green       <= pop ? head[15:8]  : 8'd0;
            blue        <= pop ? head[7:0]   : 8'd0;
            desync      <= err;
            if (err && (underflow_cnt != 8'hFF))
                underflow_cnt <= underflow_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_video_pixel_sequencer.sv
// Scoreboard bench for video_pixel_sequencer on a shrunken raster
// (16x10 total, 8x6 active) so many frames fit in a short run.
module tb_video_pixel_sequencer;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int FD = 16;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int NPIX  = HA * VA;

    logic        clock_25, reset_n;
    logic [23:0] pix_data;
    logic        pix_sof, pix_valid, pix_ready;
    logic [7:0]  red, green, blue, underflow_cnt;
    logic        syncH, syncV, actvA, frame_start, desync;

    video_pixel_sequencer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FIFO_DEPTH(FD)
    ) dut (
        .clock_25(clock_25), .reset_n(reset_n),
        .pix_data(pix_data), .pix_sof(pix_sof), .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .red(red), .green(green), .blue(blue),
        .syncH(syncH), .syncV(syncV), .actvA(actvA),
        .frame_start(frame_start), .desync(desync),
        .underflow_cnt(underflow_cnt)
    );

    initial clock_25 = 1'b0;
    always #5 clock_25 = ~clock_25;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pix_val(input int f, input int p);
        return {8'h11 + 8'(f), 16'h2233 + 16'(p * 7)};
    endfunction

    // source controls
    bit src_en = 0, src_rec = 0, src_allsof = 0, src_acc;
    int src_f = 0, src_p = 0, src_junk = 0, stall_p = -1, inj_p = -1;
    int acc_cnt = 0, junk_bad = 0;
    logic [23:0] q[$];

    // checker state
    bit chk_on = 0, sb_arm = 0;
    int pos = 0, desync_cnt = 0, desync_pos = -1, pix_cmp = 0, blank_bad = 0;
    logic [23:0] desync_rgb;
    logic        desync_act;

    // source: decide acceptance at negedge, advance and redrive after posedge
    initial begin
        pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
        forever begin
            @(negedge clock_25);
            src_acc = reset_n && pix_valid && pix_ready;
            if (reset_n && src_junk > 0 && pix_valid && !pix_ready) junk_bad++;
            @(posedge clock_25); #1;
            if (src_acc) begin
                if (src_junk > 0) src_junk--;
                else if (!src_allsof) begin
                    if (src_rec) begin q.push_back(pix_data); acc_cnt++; end
                    src_p++;
                    if (src_p == NPIX) begin src_p = 0; src_f++; end
                end
            end
            if (!src_en) begin
                pix_valid = 1'b0; pix_sof = 1'b0;
            end else if (src_junk > 0) begin
                pix_valid = 1'b1; pix_sof = 1'b0; pix_data = 24'hDE0000 | 24'(src_junk);
            end else if (src_allsof) begin
                pix_valid = 1'b1; pix_sof = 1'b1; pix_data = pix_val(src_f, 0);
            end else if (src_p == stall_p) begin
                pix_valid = 1'b0; pix_sof = 1'b0;
            end else begin
                pix_valid = 1'b1;
                pix_sof   = (src_p == 0) || (src_p == inj_p);
                pix_data  = pix_val(src_f, src_p);
            end
        end
    end

    // output monitor: scoreboard pops on active pixels of a streamed frame
    initial begin
        logic [23:0] exp_px;
        forever begin
            @(negedge clock_25);
            if (!reset_n) continue;
            if (frame_start) begin
                pos = 0;
                if (sb_arm) begin chk_on = 1; sb_arm = 0; end
            end
            if (!actvA && {red, green, blue} != 24'd0) blank_bad++;
            if (desync) begin
                desync_cnt++;
                desync_pos = pos;
                desync_rgb = {red, green, blue};
                desync_act = actvA;
                chk_on = 0;
            end else if (actvA && chk_on) begin
                exp_px = (q.size() > 0) ? q.pop_front() : 24'hxxxxxx;
                chk("pix", {8'h0, red, green, blue}, {8'h0, exp_px});
                pix_cmp++;
            end
            if (actvA) pos++;
        end
    end

    task automatic do_reset();
        src_en = 0; src_rec = 0; src_allsof = 0; src_junk = 0;
        stall_p = -1; inj_p = -1;
        @(negedge clock_25); reset_n = 1'b0;
        repeat (3) @(negedge clock_25);
        q.delete();
        desync_cnt = 0; pix_cmp = 0; blank_bad = 0; junk_bad = 0;
        acc_cnt = 0; chk_on = 0; sb_arm = 0;
        reset_n = 1'b1;
        repeat (3) @(negedge clock_25);
        #1;
    endtask

    task automatic src_start(input int f, input int junk);
        src_f = f; src_p = 0; src_junk = junk;
        src_rec = 1; sb_arm = 1; src_en = 1;
    endtask

    task automatic src_stop();
        src_en = 0; src_rec = 0;
        repeat (3) @(negedge clock_25);
        #1;
        q.delete();
    endtask

    task automatic wait_desync(input int target, input int bound, output bit seen);
        seen = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clock_25); #1;
            if (desync_cnt >= target) begin seen = 1; break; end
        end
    endtask

    initial begin
        int n, rdy_hi, c_act, c_sh, c_sv, c_fs, base;
        bit seen;
        reset_n = 1'b0;

        // reset mid-line, then release and time the first syncH
        repeat (2) @(negedge clock_25);
        reset_n = 1'b1;
        src_junk = 100000; src_en = 1;
        repeat (HT + 5) @(negedge clock_25);
        chk("pre_rst_actv", actvA, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_rgb", {red, green, blue}, 0);
        chk("rst_flags", {syncH, syncV, actvA, frame_start, desync, pix_ready}, 0);
        chk("rst_ucnt", underflow_cnt, 0);
        src_en = 0; src_junk = 0;
        @(negedge clock_25); reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock_25); #1;
            n++;
            if (n == 1) chk("fs_first", frame_start, 1);
            if (syncH) break;
        end
        chk("synch_lat", n, HA + HF + 1);

        // clean stream; FIFO fills while armed and ready must stay low
        do_reset();
        src_start(0, 0);
        for (int i = 0; i < 400 && acc_cnt < FD; i++) @(negedge clock_25);
        chk("armed_fill_reach", acc_cnt, FD);
        rdy_hi = 0; seen = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clock_25); #1;
            if (frame_start) begin seen = 1; break; end
            if (pix_ready) rdy_hi++;
        end
        chk("armed_stream_start", seen, 1);
        chk("armed_rdy", rdy_hi, 0);
        chk("armed_fill", acc_cnt, FD);
        c_act = 0; c_sh = 0; c_sv = 0; c_fs = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) begin @(negedge clock_25); #1; end
            c_act += int'(actvA); c_sh += int'(syncH);
            c_sv  += int'(syncV); c_fs += int'(frame_start);
        end
        chk("cnt_actv", c_act, NPIX);
        chk("cnt_synch", c_sh, HS * VT);
        chk("cnt_syncv", c_sv, VS * HT);
        chk("cnt_fs", c_fs, 1);
        repeat (FRAME) @(negedge clock_25);
        #1;
        chk("clean_pix_cnt", pix_cmp, 2 * NPIX);
        chk("clean_desync", desync_cnt, 0);
        chk("clean_ucnt", underflow_cnt, 0);
        chk("clean_blank", blank_bad, 0);

        // 37 non-sof pixels dropped before the first sof
        do_reset();
        src_start(0, 37);
        repeat (3 * FRAME) @(negedge clock_25);
        #1;
        chk("junk_ready", junk_bad, 0);
        chk("junk_pix_ge", pix_cmp >= 2 * NPIX, 1);
        chk("junk_desync", desync_cnt, 0);
        chk("junk_ucnt", underflow_cnt, 0);

        // source stall inside line 3 -> underflow at that pixel
        do_reset();
        stall_p = 3 * HA + 5;
        src_start(0, 0);
        wait_desync(1, 3 * FRAME, seen);
        chk("stall_seen", seen, 1);
        chk("stall_pos", desync_pos, 3 * HA + 5);
        chk("stall_rgb", desync_rgb, 0);
        chk("stall_actv", desync_act, 1);
        chk("stall_ucnt", underflow_cnt, 1);
        repeat (40) @(negedge clock_25);
        #1;
        chk("stall_once", desync_cnt, 1);
        src_stop();
        stall_p = -1;
        base = pix_cmp;
        src_start(1, 0);
        repeat (3 * FRAME) @(negedge clock_25);
        #1;
        chk("stall_recover_pix", (pix_cmp - base) >= NPIX, 1);
        chk("stall_recover_desync", desync_cnt, 1);
        chk("stall_blank", blank_bad, 0);

        // extra sof at line 2 pixel 3 -> misalignment
        do_reset();
        inj_p = 2 * HA + 3;
        src_start(0, 0);
        wait_desync(1, 3 * FRAME, seen);
        chk("inj_seen", seen, 1);
        chk("inj_pos", desync_pos, 2 * HA + 3);
        chk("inj_rgb", desync_rgb, 0);
        chk("inj_ucnt", underflow_cnt, 1);
        src_stop();
        inj_p = -1;
        base = pix_cmp;
        src_start(1, 0);
        repeat (3 * FRAME) @(negedge clock_25);
        #1;
        chk("inj_recover_pix", (pix_cmp - base) >= NPIX, 1);
        chk("inj_recover_desync", desync_cnt, 1);

        // every pixel flagged sof: one misalignment per frame, counter saturates
        do_reset();
        src_allsof = 1; src_en = 1;
        wait_desync(100, 110 * FRAME, seen);
        chk("sat_seen100", seen, 1);
        chk("sat_100", underflow_cnt, 100);
        wait_desync(255, 160 * FRAME, seen);
        chk("sat_seen255", seen, 1);
        chk("sat_255", underflow_cnt, 255);
        wait_desync(300, 50 * FRAME, seen);
        chk("sat_seen300", seen, 1);
        chk("sat_300", underflow_cnt, 255);
        src_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_pixel_sequencer.md
Name: video_pixel_sequencer

Overview:
- Upstream neighbour of the HDMI output stage. Generates 640x480@60 raster timing on the pixel clock.
- Accepts a pixel stream from a frame source over a valid/ready handshake, buffers it in a small FIFO, and presents registered red/green/blue/syncH/syncV/actvA, aligned, to the three TMDS encoders.
- Detects and recovers from stream underflow and frame misalignment.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch (line total 800)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch (frame total 525)
- FIFO_DEPTH, 16, pixel FIFO entries (power of two, at least 4)

Ports:
- clock_25  in  1  pixel clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- pix_data  in  24  {R[23:16], G[15:8], B[7:0]}
- pix_sof  in  1  marks the pixel at (0,0) of a frame
- pix_valid  in  1  source holds a pixel
- pix_ready  out  1  block accepts a pixel this cycle
- red, green, blue  out  8 each  pixel to the encoders
- syncH, syncV  out  1 each  active-high sync pulses
- actvA  out  1  active video
- frame_start  out  1  one-cycle pulse at counter (0,0)
- desync  out  1  one-cycle pulse on underflow or misalignment
- underflow_cnt  out  8  saturating error count

Behaviour:
- Reset (asynchronous on reset_n low): contX=0, contY=0, FIFO empty, state WAIT_SOF. All outputs 0, underflow_cnt 0, pix_ready 0 while reset_n is low.
- Counters: contX counts 0..799 and wraps to 0. contY increments when contX==799 and wraps 524 to 0. Both counters free-run in every state.
- Timing outputs, registered, 1-cycle latency from the counters:
  - syncH = contX in [656,752)
  - syncV = contY in [490,492)
  - actvA = (contX<640) && (contY<480)
  - frame_start = (contX==0 && contY==0)
- FIFO: 25 bits wide {sof, data}. Push = pix_valid && pix_ready. pix_ready = !full in ARMED/STREAM, 1 in WAIT_SOF. No bypass: a push and a pop in the same cycle on an empty FIFO counts as underflow. Push and pop in the same cycle when non-empty leaves the count unchanged.
- State WAIT_SOF:
  - Accepted pixels with pix_sof=0 are discarded.
  - An accepted pixel with pix_sof=1 is written to the FIFO; next state ARMED.
- State ARMED:
  - Normal pushes, no pops.
  - The cycle contX==799 && contY==524 moves to STREAM, so the first pop occurs at (0,0).
- State STREAM:
  - Pop on every cycle where contX<640 && contY<480. The popped data drives red/green/blue on the next edge, together with actvA.
  - Misalignment: popped sof=1 at a position other than (0,0), or popped sof=0 at (0,0).
  - Underflow: FIFO empty when a pop is required.
  - On either error: output black for that pixel, pulse desync, increment underflow_cnt (holds at 255), flush FIFO, and go to WAIT_SOF.
- red/green/blue are 0 whenever actvA is 0 or the state is not STREAM.
- On error, the flush takes priority over any push in the same cycle.
- Timing continues unbroken through an error. Syncs never glitch.

Test Plan:
- Reset mid-line (contX=300), then release: all outputs 0, contX restarts at 0. syncH first asserts on the output 657 cycles after release (counter reaches 656, 1-cycle register).
- Source streams a full frame with pix_sof on the first pixel, always valid: pixel (0,0)=0x112233 appears on red/green/blue = 0x11/0x22/0x33 with actvA=1, one cycle after frame_start's counter. Counts: 640 actvA cycles per line, 480 lines. syncV covers exactly 2x800 cycles.
- Source presents 37 pixels without sof, then a sof pixel: the 37 are dropped with pix_ready=1. Streaming begins at the next frame and underflow_cnt stays 0.
- Source stalls (pix_valid=0) from pixel 100 of line 5: pixel 100 outputs 0/0/0, desync pulses once, underflow_cnt=1. Recovery occurs at the next sof frame with correct output.
- Extra sof injected at line 2, pixel 10: desync pulses once and underflow_cnt increments. After 300 forced errors, underflow_cnt reads 255.
- FIFO full in ARMED with pix_valid held high: pix_ready=0 for the remainder of ARMED, and no data is lost or duplicated after STREAM begins.
